// File: rtl/ps2_keyboard_sequencer.sv
// Drives the PS/2 transceiver command port: keyboard reset and self-test check,
// lock-LED writes with retry, and scan-code pass-through while idle.
module ps2_keyboard_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 2_500_000,
    parameter int unsigned BAT_TIMEOUT = 50_000_000,
    parameter int unsigned MAX_RETRIES = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    output logic [7:0] ps2_command,
    output logic       ps2_send_command,
    input  logic       ps2_command_was_sent,
    input  logic       ps2_error_timed_out,
    input  logic [7:0] ps2_received_data,
    input  logic       ps2_received_data_en,
    input  logic       led_req,
    input  logic [2:0] led_value,
    output logic       led_ready,
    output logic       led_done,
    output logic       led_fail,
    output logic [7:0] key_data,
    output logic       key_valid,
    output logic       init_done,
    output logic       init_error
);

    localparam int unsigned CNT_W   = 26;
    localparam int unsigned RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] CMD_SET_LEDS  = 8'hED;
    localparam logic [7:0] BYTE_ACK      = 8'hFA;
    localparam logic [7:0] BYTE_RESEND   = 8'hFE;
    localparam logic [7:0] BYTE_BAT_OK   = 8'hAA;
    localparam logic [7:0] BYTE_BAT_FAIL = 8'hFC;

    localparam logic [CNT_W-1:0]   ACK_LIMIT   = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0]   BAT_LIMIT   = CNT_W'(BAT_TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    typedef enum logic [3:0] {
        RST_CMD,
        RST_ACK,
        BAT_WAIT,
        IDLE,
        LED_CMD,
        LED_ACK1,
        LED_VAL,
        LED_ACK2,
        ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [2:0]         led_value_q, led_value_d;

    logic [7:0] cmd_d;
    logic       send_d;
    logic       led_ready_d;
    logic       led_done_d;
    logic       led_fail_d;
    logic [7:0] key_data_d;
    logic       key_valid_d;
    logic       init_done_d;
    logic       init_error_d;

    logic fail;
    logic byte_seen;
    logic in_init;

    assign in_init = (state_q == RST_CMD) || (state_q == RST_ACK) || (state_q == BAT_WAIT);

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        led_value_d  = led_value_q;
        cmd_d        = ps2_command;
        send_d       = 1'b0;
        led_done_d   = 1'b0;
        led_fail_d   = 1'b0;
        key_data_d   = key_data;
        key_valid_d  = 1'b0;
        init_done_d  = init_done;
        init_error_d = init_error;
        fail         = 1'b0;
        byte_seen    = 1'b0;
        cnt_d        = cnt_q;

        case (state_q)
            RST_CMD, LED_CMD, LED_VAL: begin
                cmd_d = (state_q == RST_CMD) ? CMD_RESET :
                        (state_q == LED_CMD) ? CMD_SET_LEDS : {5'b0, led_value_q};
                // Transfer results only count while our send is up; a low send is the release gap.
                if (!ps2_send_command) begin
                    send_d = 1'b1;
                end else if (ps2_command_was_sent) begin
                    state_d = (state_q == RST_CMD) ? RST_ACK :
                              (state_q == LED_CMD) ? LED_ACK1 : LED_ACK2;
                end else if (ps2_error_timed_out) begin
                    fail = 1'b1;
                end else begin
                    send_d = 1'b1;
                end
            end

            RST_ACK, LED_ACK1, LED_ACK2: begin
                if (ps2_received_data_en) begin
                    byte_seen = 1'b1;
                    if (ps2_received_data == BYTE_ACK) begin
                        if (state_q == RST_ACK) begin
                            state_d = BAT_WAIT;
                        end else if (state_q == LED_ACK1) begin
                            state_d = LED_VAL;
                        end else begin
                            state_d    = IDLE;
                            led_done_d = 1'b1;
                        end
                    end else if (ps2_received_data == BYTE_RESEND) begin
                        fail = 1'b1;
                    end
                end else if (cnt_q >= ACK_LIMIT) begin
                    fail = 1'b1;
                end
            end

            BAT_WAIT: begin
                if (ps2_received_data_en) begin
                    byte_seen = 1'b1;
                    if (ps2_received_data == BYTE_BAT_OK) begin
                        state_d     = IDLE;
                        init_done_d = 1'b1;
                    end else if (ps2_received_data == BYTE_BAT_FAIL) begin
                        fail = 1'b1;
                    end
                end else if (cnt_q >= BAT_LIMIT) begin
                    fail = 1'b1;
                end
            end

            IDLE: begin
                if (ps2_received_data_en) begin
                    key_data_d  = ps2_received_data;
                    key_valid_d = 1'b1;
                end
                if (led_req) begin
                    led_value_d = led_value;
                    retry_d     = '0;
                    state_d     = LED_CMD;
                end
            end

            ERROR: begin
                state_d = ERROR;
            end

            default: begin
                state_d = RST_CMD;
            end
        endcase

        // Failed attempt: retry the sequence from its first command, or give up
        if (fail) begin
            if (retry_q < RETRY_LIMIT) begin
                retry_d = retry_q + RETRY_W'(1);
                state_d = in_init ? RST_CMD : LED_CMD;
            end else if (in_init) begin
                state_d      = ERROR;
                init_error_d = 1'b1;
            end else begin
                state_d    = IDLE;
                led_done_d = 1'b1;
                led_fail_d = 1'b1;
            end
        end

        if ((state_d != state_q) || byte_seen) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        led_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q          <= RST_CMD;
            cnt_q            <= '0;
            retry_q          <= '0;
            led_value_q      <= '0;
            ps2_command      <= 8'h00;
            ps2_send_command <= 1'b0;
            led_ready        <= 1'b0;
            led_done         <= 1'b0;
            led_fail         <= 1'b0;
            key_data         <= 8'h00;
            key_valid        <= 1'b0;
            init_done        <= 1'b0;
            init_error       <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            retry_q          <= retry_d;
            led_value_q      <= led_value_d;
            ps2_command      <= cmd_d;
            ps2_send_command <= send_d;
            led_ready        <= led_ready_d;
            led_done         <= led_done_d;
            led_fail         <= led_fail_d;
            key_data         <= key_data_d;
            key_valid        <= key_valid_d;
            init_done        <= init_done_d;
            init_error       <= init_error_d;
        end
    end

endmodule

// File: doc/ps2_keyboard_sequencer.md
# ps2_keyboard_sequencer

Sequences the PS/2 transceiver (`PS2_Controller`) for a keyboard. It sends the keyboard reset command and checks the self-test result, then programs the lock LEDs on request. Scan-code bytes received while idle pass through to the game logic. The block sits between `PS2_Controller` and the game logic, and it is the only driver of the transceiver's command port.

## Interface
Parameters:
- `ACK_TIMEOUT`, 2_500_000: cycles to wait for an ACK byte (50 ms at 50 MHz).
- `BAT_TIMEOUT`, 50_000_000: cycles to wait for the self-test byte 0xAA after the ACK to 0xFF.
- `MAX_RETRIES`, 3: number of re-sends per command after a failed attempt.

Ports:
- `CLOCK_50`  in  1: the only clock.
- `reset`  in  1: synchronous, active-high.
- `ps2_command`  out  8: byte for the transceiver. The top level zero-extends it to `the_command[15:0]`.
- `ps2_send_command`  out  1: drives the transceiver's `send_command`.
- `ps2_command_was_sent`  in  1: transceiver's `command_was_sent`.
- `ps2_error_timed_out`  in  1: transceiver's `error_communication_timed_out`.
- `ps2_received_data`  in  8: `received_data[7:0]` from the transceiver.
- `ps2_received_data_en`  in  1: one-cycle strobe; a byte has arrived.
- `led_req`  in  1: request to write the LEDs. Level; the requester holds it until accepted.
- `led_value`  in  3: {caps, num, scroll}, sampled at acceptance.
- `led_ready`  out  1: high only in IDLE. Accept = `led_req && led_ready`.
- `led_done`  out  1: one-cycle pulse when an LED write finishes.
- `led_fail`  out  1: valid with `led_done`; 1 means retries were exhausted.
- `key_data`  out  8: received scan-code byte.
- `key_valid`  out  1: one-cycle pulse qualifying `key_data`.
- `init_done`  out  1: set after the self-test passes; held until reset.
- `init_error`  out  1: set after initialisation fails; held until reset.

## Operation
- FSM states: RST_CMD, RST_ACK, BAT_WAIT, IDLE, LED_CMD, LED_ACK1, LED_VAL, LED_ACK2, ERROR.
- Command states (RST_CMD, LED_CMD, LED_VAL):
  - Drive `ps2_command` (0xFF, 0xED, {5'b0, led_value_q} respectively) and assert `ps2_send_command`.
  - Hold both until `ps2_command_was_sent` or `ps2_error_timed_out` is sampled high.
  - Then deassert `ps2_send_command` for at least 1 cycle. The transceiver only leaves its end-transfer state when send is low.
  - `was_sent` leads to the matching ACK/wait state. `timed_out` counts as a failed attempt.
- ACK states (RST_ACK, LED_ACK1, LED_ACK2):
  - A received 0xFA advances the FSM: RST_ACK → BAT_WAIT, LED_ACK1 → LED_VAL, LED_ACK2 → IDLE with `led_done`=1, `led_fail`=0.
  - A received 0xFE (resend), or the cycle counter reaching `ACK_TIMEOUT`, counts as a failed attempt.
  - Any other byte is discarded and is not forwarded.
- BAT_WAIT:
  - 0xAA → IDLE and set `init_done`.
  - 0xFC, or `BAT_TIMEOUT` reached → failed attempt.
- Failed attempt:
  - If retries < `MAX_RETRIES`: increment the retry count and return to the command state of the current sequence. The reset sequence restarts at RST_CMD; LED_VAL failures re-enter LED_CMD, because the keyboard expects 0xED again.
  - Otherwise, in the init sequence: go to ERROR, set `init_error`, stay there until reset.
  - Otherwise, in the LED sequence: go to IDLE with `led_done`=1, `led_fail`=1.
- The retry count clears on entry to RST_CMD from reset and on each LED acceptance. It does not clear between the two bytes of one LED write.
- IDLE:
  - Each `ps2_received_data_en` gives `key_data` = byte and `key_valid`=1 on the next cycle.
  - On acceptance, `led_value` is latched into `led_value_q` and the FSM goes to LED_CMD.
- `led_req` outside IDLE is not accepted; `led_ready`=0 there.
- Bytes arriving in any non-IDLE state are never forwarded. This includes scan codes interleaved during an LED write; losing them is accepted.
- The timeout counter is 26 bits. It clears on every state change and on every received byte in ACK/BAT states, and saturates.

## Timing
- Reset values:
  - `ps2_command`=0x00; `ps2_send_command`, `led_ready`, `led_done`, `led_fail`, `key_valid`, `init_done`, `init_error` = 0; `key_data`=0x00.
  - FSM = RST_CMD, so initialisation starts automatically on the first cycle after reset.
- All outputs are registered.
- `ps2_send_command` rises 1 cycle after entry to a command state.
- Release gap: at least 1 cycle of `ps2_send_command`=0 between consecutive commands.
- `key_valid` latency: 1 cycle after `ps2_received_data_en`.
- `led_done` is asserted 1 cycle after the final ACK byte's strobe. `led_ready` rises in the same cycle.
- Reset mid-sequence: abort immediately; outputs return to reset values; the sequence restarts at RST_CMD.
- `ps2_received_data_en` and `ps2_command_was_sent` in the same cycle: `was_sent` is processed; the byte is ignored.
- Timeout expiry and an arriving byte in the same cycle: the byte wins.

## Test plan
Benches override `ACK_TIMEOUT`=1000, `BAT_TIMEOUT`=5000, `MAX_RETRIES`=2.
- Clean init: after reset, expect `ps2_command`=0xFF with send high; pulse `was_sent`, feed 0xFA then 0xAA → `init_done`=1, `led_ready`=1, exactly one send.
- Scan pass-through: in IDLE feed 0x1C, 0xF0, 0x1C → three `key_valid` pulses with matching `key_data`, each 1 cycle after the strobe.
- LED write: `led_req` with `led_value`=3'b101 → commands 0xED then 0x05, each ACKed with 0xFA, with send low ≥1 cycle between them → `led_done`=1, `led_fail`=0; 0xFA bytes not forwarded.
- Resend/timeout: answer 0xFE to 0xED, then no ACK for 1000 cycles → 0xED re-sent twice; third failure → `led_done`=1 with `led_fail`=1.
- Init failure: the transceiver reports `timed_out` on all 3 attempts → `init_error`=1, FSM holds in ERROR; reset → 0xFF re-sent.
- Reset during LED_VAL with send high → send=0 the next cycle, all flags cleared, 0xFF issued again.
